// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: execution, game and direction
// states, the one-hot pad codes, and the reverse-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        EXEC_CHECK      = 2'd0,
        EXEC_INPUT      = 2'd1,
        EXEC_WAIT_LOGIC = 2'd2,
        EXEC_DISPLAY    = 2'd3
    } exec_state_t;

    typedef enum logic [1:0] {
        GAME_INIT = 2'd0,
        GAME_RUN  = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_state_t;

    localparam logic [3:0] PAD_RIGHT = 4'b1000;
    localparam logic [3:0] PAD_LEFT  = 4'b0100;
    localparam logic [3:0] PAD_DOWN  = 4'b0010;
    localparam logic [3:0] PAD_UP    = 4'b0001;

    function automatic dir_state_t reverse_dir(input dir_state_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/led_scanner.sv
// Row-multiplexed 8x8 LED scanner with registered row/column drive.
// Define SNAKE_BLINK_EN to blink the head LED while the game is over.
module led_scanner #(
    parameter int FRAMES_PER_TICK = 1,
    parameter int BLINK_FRAMES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        over,
    input  logic [5:0]  head_pos,
    input  logic [63:0] led_array,
    output logic        frames_done,
    output logic [7:0]  row_cathode,
    output logic [7:0]  column_anode
);
    localparam int FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

    logic [2:0]    row_q;
    logic [FW-1:0] frame_q;
    logic          frame_end;
    logic [7:0]    blank_mask;

    assign frame_end   = start && (row_q == 3'd7);
    assign frames_done = frame_end && (frame_q == FW'(FRAMES_PER_TICK - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || !start) begin
            row_q   <= 3'd0;
            frame_q <= '0;
        end else begin
            row_q <= row_q + 3'd1;
            if (frame_end)
                frame_q <= frames_done ? '0 : frame_q + 1'b1;
        end
    end

`ifdef SNAKE_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          blink_off_q;

    // Only frames shown while the game is over advance the blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (frame_end && over) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blank_mask = (over && blink_off_q && (head_pos[5:3] == row_q))
                        ? (8'b1 << head_pos[2:0]) : 8'h00;
`else
    logic unused_blink_inputs;
    assign unused_blink_inputs = ^{over, head_pos, BLINK_FRAMES[0]};
    assign blank_mask          = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst || !start) begin
            row_cathode  <= 8'hFF;
            column_anode <= 8'h00;
        end else begin
            row_cathode  <= ~(8'b1 << row_q);
            column_anode <= led_array[{row_q, 3'b000} +: 8] & ~blank_mask;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Snake game execution controller: CHECK/INPUT/WAIT_LOGIC/DISPLAY loop,
// direction filter, logic tick and LED scan. Optional SNAKE_BLINK_EN blinks the head in OVER.
module game_sequencer
    import snake_pkg::*;
#(
    parameter int FRAMES_PER_TICK = 1,
    parameter int BLINK_FRAMES    = 4
) (
    input  logic        in_clka,
    input  logic        in_restart,
    input  logic [3:0]  in_direction_in,
    input  logic        in_logic_done,
    input  logic        in_collision,
    input  logic [5:0]  in_head_pos,
    input  logic [63:0] in_led_array_flat,
    output logic        out_logic_tick,
    output logic [1:0]  out_game_state,
    output logic [1:0]  out_direction_state,
    output logic [1:0]  out_execution_state,
    output logic [7:0]  out_row_cathode,
    output logic [7:0]  out_column_anode
);
    exec_state_t exec_q, exec_d;
    game_state_t game_q, game_d;
    dir_state_t  dir_q, dir_d;
    dir_state_t  pend_dir_q, pend_dir_d;
    logic        pend_valid_q, pend_valid_d;
    logic        press_valid;
    dir_state_t  press_dir;
    logic        frames_done;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        press_valid = 1'b1;
        press_dir   = DIR_RIGHT;
        case (in_direction_in)
            PAD_RIGHT: press_dir = DIR_RIGHT;
            PAD_LEFT:  press_dir = DIR_LEFT;
            PAD_DOWN:  press_dir = DIR_DOWN;
            PAD_UP:    press_dir = DIR_UP;
            default:   press_valid = 1'b0;
        endcase
        if (game_q == GAME_OVER)
            press_valid = 1'b0;
        if (game_q == GAME_RUN && press_dir == reverse_dir(dir_q))
            press_valid = 1'b0;
    end

    always_comb begin
        exec_d       = exec_q;
        game_d       = game_q;
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        case (exec_q)
            EXEC_CHECK: begin
                case (game_q)
                    GAME_INIT: begin
                        if (pend_valid_q || press_valid) begin
                            game_d = GAME_RUN;
                            exec_d = EXEC_INPUT;
                        end else begin
                            exec_d = EXEC_DISPLAY;
                        end
                    end
                    GAME_RUN: exec_d = EXEC_INPUT;
                    default:  exec_d = EXEC_DISPLAY;
                endcase
            end
            EXEC_INPUT: begin
                if (pend_valid_q)
                    dir_d = pend_dir_q;
                pend_valid_d = 1'b0;
                exec_d       = EXEC_WAIT_LOGIC;
            end
            EXEC_WAIT_LOGIC: begin
                if (in_logic_done) begin
                    if (in_collision)
                        game_d = GAME_OVER;
                    exec_d = EXEC_DISPLAY;
                end
            end
            default: begin
                if (frames_done)
                    exec_d = EXEC_CHECK;
            end
        endcase
        // A press in the INPUT cycle itself survives the clear for the next tick.
        if (press_valid) begin
            pend_dir_d   = press_dir;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            exec_q       <= EXEC_CHECK;
            game_q       <= GAME_INIT;
            dir_q        <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
        end else begin
            exec_q       <= exec_d;
            game_q       <= game_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    led_scanner #(
        .FRAMES_PER_TICK (FRAMES_PER_TICK),
        .BLINK_FRAMES    (BLINK_FRAMES)
    ) u_led_scanner (
        .clk          (in_clka),
        .rst          (in_restart),
        .start        (exec_q == EXEC_DISPLAY),
        .over         (game_q == GAME_OVER),
        .head_pos     (in_head_pos),
        .led_array    (in_led_array_flat),
        .frames_done  (frames_done),
        .row_cathode  (out_row_cathode),
        .column_anode (out_column_anode)
    );

    assign out_logic_tick      = (exec_q == EXEC_INPUT);
    assign out_game_state      = game_q;
    assign out_direction_state = dir_q;
    assign out_execution_state = exec_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (default parameters).
// Blink expectations follow SNAKE_BLINK_EN when the bench is built with it.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        restart;
    logic [3:0]  dir_in;
    logic        done;
    logic        collision;
    logic [5:0]  head;
    logic [63:0] arr;
    logic        tick;
    logic [1:0]  game;
    logic [1:0]  dirs;
    logic [1:0]  exec;
    logic [7:0]  cath;
    logic [7:0]  anode;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ARR_A = 64'h8040_2010_0804_0201;
    localparam logic [63:0] ARR_B = 64'hFF00_A55A_3C81_7E18;
    localparam logic [63:0] HEAD_BIT = 64'h0000_0000_2000_0000;

`ifdef SNAKE_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic [7:0] cath_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    always #5 clk = ~clk;

    game_sequencer dut (
        .in_clka             (clk),
        .in_restart          (restart),
        .in_direction_in     (dir_in),
        .in_logic_done       (done),
        .in_collision        (collision),
        .in_head_pos         (head),
        .in_led_array_flat   (arr),
        .out_logic_tick      (tick),
        .out_game_state      (game),
        .out_direction_state (dirs),
        .out_execution_state (exec),
        .out_row_cathode     (cath),
        .out_column_anode    (anode)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after exec entered DISPLAY; returns at the CHECK cycle that
    // shows row 7.
    task automatic run_display(input logic [63:0] blank);
        logic [63:0] vis;
        logic [7:0]  exp_row;
        vis = arr & ~blank;
        for (int r = 0; r < 8; r++) begin
            step();
            exp_row = vis[r*8 +: 8];
            check("cathode", {56'd0, cath}, {56'd0, cath_tab[r]});
            check("anode", {56'd0, anode}, {56'd0, exp_row});
            check("tick_low_in_scan", {63'd0, tick}, 64'd0);
        end
    endtask

    initial begin
        restart   = 1'b1;
        dir_in    = 4'b0000;
        done      = 1'b0;
        collision = 1'b0;
        head      = 6'd0;
        arr       = ARR_A;
        step();
        step();
        check("rst_exec", {62'd0, exec}, 64'd0);
        check("rst_game", {62'd0, game}, 64'd0);
        check("rst_dir", {62'd0, dirs}, 64'd3);
        check("rst_tick", {63'd0, tick}, 64'd0);
        check("rst_cathode", {56'd0, cath}, 64'hFF);
        check("rst_anode", {56'd0, anode}, 64'h00);
        restart = 1'b0;

        // Idle: INIT alternates CHECK/DISPLAY with no tick.
        for (int v = 0; v < 4; v++) begin
            step();
            check("idle_exec_display", {62'd0, exec}, 64'd3);
            check("idle_game", {62'd0, game}, 64'd0);
            run_display(64'd0);
            check("idle_exec_check", {62'd0, exec}, 64'd0);
        end

        // First press starts the game; done during INPUT is ignored.
        dir_in = 4'b1000;
        step();
        check("start_exec_input", {62'd0, exec}, 64'd1);
        check("start_game_run", {62'd0, game}, 64'd1);
        check("start_dir", {62'd0, dirs}, 64'd3);
        check("start_tick", {63'd0, tick}, 64'd1);
        dir_in = 4'b0000;
        done   = 1'b1;
        step();
        check("wait_entry", {62'd0, exec}, 64'd2);
        check("tick_one_cycle", {63'd0, tick}, 64'd0);
        done = 1'b0;
        step();
        check("done_in_input_ignored", {62'd0, exec}, 64'd2);
        step();
        step();
        done = 1'b1;
        step();
        check("wait5_to_display", {62'd0, exec}, 64'd3);
        done = 1'b0;
        run_display(64'd0);
        check("run_back_to_check", {62'd0, exec}, 64'd0);
        check("run_game", {62'd0, game}, 64'd1);

        // Reverse press alone is dropped; a later UP press is latched.
        dir_in = 4'b0100;
        step();
        check("tick2", {63'd0, tick}, 64'd1);
        dir_in = 4'b0000;
        step();
        done = 1'b1;
        step();
        check("left_ignored_dir", {62'd0, dirs}, 64'd3);
        done   = 1'b0;
        dir_in = 4'b0001;
        run_display(64'd0);
        dir_in = 4'b0000;
        step();
        check("tick3", {63'd0, tick}, 64'd1);
        step();
        check("up_latched", {62'd0, dirs}, 64'd0);

        // Multi-hot, then a reverse (DOWN while UP), both ignored.
        dir_in = 4'b1100;
        done   = 1'b1;
        step();
        done = 1'b0;
        run_display(64'd0);
        dir_in = 4'b0010;
        step();
        dir_in = 4'b0000;
        step();
        check("multihot_reverse_ignored", {62'd0, dirs}, 64'd0);

        // Collision: OVER, no further ticks, head blinks when enabled.
        head      = 6'd29;
        arr       = ARR_B;
        done      = 1'b1;
        collision = 1'b1;
        step();
        check("over_exec", {62'd0, exec}, 64'd3);
        check("over_game", {62'd0, game}, 64'd2);
        done      = 1'b0;
        collision = 1'b0;
        dir_in    = 4'b0100;
        for (int f = 0; f < 10; f++) begin
            run_display((BLINK_ON && ((f / 4) % 2 == 1)) ? HEAD_BIT : 64'd0);
            check("over_exec_check", {62'd0, exec}, 64'd0);
            check("over_game_hold", {62'd0, game}, 64'd2);
            step();
            check("over_no_input", {62'd0, exec}, 64'd3);
        end
        dir_in = 4'b0000;

        // Restart out of OVER, then restart again during WAIT_LOGIC.
        run_display(64'd0);
        restart = 1'b1;
        step();
        check("restart_cathode", {56'd0, cath}, 64'hFF);
        check("restart_game", {62'd0, game}, 64'd0);
        restart = 1'b0;
        dir_in  = 4'b0010;
        step();
        check("init_down_tick", {63'd0, tick}, 64'd1);
        dir_in = 4'b0000;
        step();
        check("init_down_dir", {62'd0, dirs}, 64'd1);
        restart   = 1'b1;
        done      = 1'b1;
        collision = 1'b1;
        step();
        check("mid_rst_exec", {62'd0, exec}, 64'd0);
        check("mid_rst_game", {62'd0, game}, 64'd0);
        check("mid_rst_dir", {62'd0, dirs}, 64'd3);
        check("mid_rst_tick", {63'd0, tick}, 64'd0);
        check("mid_rst_cathode", {56'd0, cath}, 64'hFF);
        check("mid_rst_anode", {56'd0, anode}, 64'h00);
        restart = 1'b0;
        step();
        check("late_done_exec", {62'd0, exec}, 64'd3);
        check("late_done_game", {62'd0, game}, 64'd0);
        done      = 1'b0;
        collision = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
